// File: rtl/divisor_secuencial.sv
// Sequential signed divider: restoring shift-subtract on magnitudes,
// one quotient bit per enabled clock, then a sign-correction step.
module divisor_secuencial #(
    parameter int WIDTH_A = 10,
    parameter int WIDTH_B = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               enable,
    input  logic               start,
    input  logic [WIDTH_A-1:0] A,
    input  logic [WIDTH_B-1:0] B,
    output logic [WIDTH_A-1:0] QUOTIENT,
    output logic [WIDTH_B-1:0] REMAINDER,
    output logic               busy,
    output logic               done,
    output logic               div_by_zero,
    output logic               overflow
);

    localparam int CW = $clog2(WIDTH_A + 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        SIGN
    } state_t;

    state_t             state_q;
    logic [WIDTH_A-1:0] quo_q;
    logic [WIDTH_B:0]   rem_q;
    logic [WIDTH_B-1:0] dvsr_q;
    logic [CW-1:0]      cnt_q;
    logic               neg_q;
    logic               sa_q;
    logic               ovf_q;
    logic               dzp_q;

    logic [WIDTH_A-1:0] a_mag;
    logic [WIDTH_B-1:0] b_mag;
    logic [WIDTH_B+1:0] rem_sh;
    logic [WIDTH_B+1:0] trial;
    logic               trial_neg;
    logic               a_min;
    logic               b_m1;
    logic               b_zero;
    logic               last_it;

    assign a_mag  = A[WIDTH_A-1] ? -A : A;
    assign b_mag  = B[WIDTH_B-1] ? -B : B;
    assign a_min  = (A == {1'b1, {(WIDTH_A-1){1'b0}}});
    assign b_m1   = &B;
    assign b_zero = (B == '0);

    // Partial remainder stays below |B|, so the MSB of trial is a clean sign.
    assign rem_sh    = {rem_q, quo_q[WIDTH_A-1]};
    assign trial     = rem_sh - {2'b00, dvsr_q};
    assign trial_neg = trial[WIDTH_B+1];
    assign last_it   = (cnt_q == CW'(WIDTH_A - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            quo_q       <= '0;
            rem_q       <= '0;
            dvsr_q      <= '0;
            cnt_q       <= '0;
            neg_q       <= 1'b0;
            sa_q        <= 1'b0;
            ovf_q       <= 1'b0;
            dzp_q       <= 1'b0;
            QUOTIENT    <= '0;
            REMAINDER   <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
        end else if (enable) begin
            done <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (dzp_q) begin
                        dzp_q       <= 1'b0;
                        QUOTIENT    <= '1;
                        REMAINDER   <= '0;
                        div_by_zero <= 1'b1;
                        overflow    <= 1'b0;
                        done        <= 1'b1;
                    end else if (start) begin
                        if (b_zero) begin
                            dzp_q <= 1'b1;
                        end else begin
                            quo_q   <= a_mag;
                            dvsr_q  <= b_mag;
                            sa_q    <= A[WIDTH_A-1];
                            neg_q   <= A[WIDTH_A-1] ^ B[WIDTH_B-1];
                            ovf_q   <= a_min & b_m1;
                            rem_q   <= '0;
                            cnt_q   <= '0;
                            busy    <= 1'b1;
                            state_q <= RUN;
                        end
                    end
                end
                RUN: begin
                    quo_q <= {quo_q[WIDTH_A-2:0], ~trial_neg};
                    rem_q <= trial_neg ? rem_sh[WIDTH_B:0]
                                       : trial[WIDTH_B:0];
                    cnt_q <= cnt_q + CW'(1);
                    if (last_it) state_q <= SIGN;
                end
                SIGN: begin
                    QUOTIENT    <= neg_q ? -quo_q : quo_q;
                    REMAINDER   <= sa_q ? -rem_q[WIDTH_B-1:0]
                                        : rem_q[WIDTH_B-1:0];
                    overflow    <= ovf_q;
                    div_by_zero <= 1'b0;
                    done        <= 1'b1;
                    busy        <= 1'b0;
                    state_q     <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_divisor_secuencial.sv
// Bench for divisor_secuencial: transaction-level model with per-cycle
// output compare, directed literal cases and randomized traffic.
module tb_divisor_secuencial;

    localparam int WA = 10;
    localparam int WB = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic          enable;
    logic          start;
    logic [WA-1:0] A;
    logic [WB-1:0] B;
    logic [WA-1:0] QUOTIENT;
    logic [WB-1:0] REMAINDER;
    logic          busy;
    logic          done;
    logic          div_by_zero;
    logic          overflow;

    divisor_secuencial #(.WIDTH_A(WA), .WIDTH_B(WB)) dut (
        .clk(clk),
        .rst(rst),
        .enable(enable),
        .start(start),
        .A(A),
        .B(B),
        .QUOTIENT(QUOTIENT),
        .REMAINDER(REMAINDER),
        .busy(busy),
        .done(done),
        .div_by_zero(div_by_zero),
        .overflow(overflow)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    function automatic void check(string name, logic [31:0] act,
                                  logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endfunction

    // Model: results from Verilog signed / and %, completion after a
    // fixed number of enabled edges.
    logic [WA-1:0] m_q, p_q;
    logic [WB-1:0] m_r, p_r;
    logic m_busy, m_done, m_dz, m_ov, p_dz, p_ov;
    int   m_left;
    bit   m_valid = 1'b0;
    int   ma, mb, mqi, mri;

    always @(posedge clk) begin
        if (rst) begin
            m_valid = 1'b1;
            m_q = '0; m_r = '0;
            m_busy = 0; m_done = 0; m_dz = 0; m_ov = 0;
            m_left = 0;
        end else if (m_valid && enable) begin
            m_done = 1'b0;
            if (m_left > 0) begin
                m_left--;
                if (m_left == 0) begin
                    m_q = p_q; m_r = p_r;
                    m_dz = p_dz; m_ov = p_ov;
                    m_done = 1'b1; m_busy = 1'b0;
                end
            end else if (start) begin
                ma = int'($signed(A));
                mb = int'($signed(B));
                if (mb == 0) begin
                    p_q = '1; p_r = '0; p_dz = 1; p_ov = 0;
                    m_left = 1;
                end else begin
                    mqi = ma / mb;
                    mri = ma % mb;
                    p_q = mqi[WA-1:0];
                    p_r = mri[WB-1:0];
                    p_dz = 0;
                    p_ov = (ma == -(1 << (WA-1))) && (mb == -1);
                    m_left = WA + 1;
                    m_busy = 1'b1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            check("cyc_quotient", QUOTIENT, m_q);
            check("cyc_remainder", REMAINDER, m_r);
            check("cyc_busy", busy, m_busy);
            check("cyc_done", done, m_done);
            check("cyc_div_by_zero", div_by_zero, m_dz);
            check("cyc_overflow", overflow, m_ov);
        end
    end

    task automatic run_div(input int a, input int b,
                           input int eq, input int er,
                           input bit eov, input bit edz,
                           input int elat, input int ebusy,
                           input bit drop, input bit poke);
        int edges;
        int bcnt;
        bit got;
        @(negedge clk);
        A = WA'(a);
        B = WB'(b);
        enable = 1'b1;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        bcnt = busy ? 1 : 0;
        edges = 0;
        got = 1'b0;
        while (!got && edges < 40) begin
            @(posedge clk);
            edges++;
            #1;
            if (busy) bcnt++;
            if (done) got = 1'b1;
            if (drop && edges == 4) enable = 1'b0;
            if (drop && edges == 7) enable = 1'b1;
            if (poke && edges == 2) begin
                A = WA'(5); B = WB'(3); start = 1'b1;
            end
            if (poke && edges == 3) start = 1'b0;
        end
        check("done_seen", got, 1'b1);
        check("latency", edges, elat);
        check("busy_cycles", bcnt, ebusy);
        check("quotient", QUOTIENT, eq[WA-1:0]);
        check("remainder", REMAINDER, er[WB-1:0]);
        check("overflow", overflow, eov);
        check("div_by_zero", div_by_zero, edz);
    endtask

    initial begin
        bit seen;
        rst = 1'b1; enable = 1'b1; start = 1'b0;
        A = '0; B = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        check("rst_quotient", QUOTIENT, 0);
        check("rst_remainder", REMAINDER, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_dz", div_by_zero, 0);
        check("rst_ovf", overflow, 0);

        run_div(100, 7, 14, 2, 0, 0, 11, 11, 0, 0);
        run_div(-100, 7, 'h3F2, 'h1E, 0, 0, 11, 11, 0, 0);
        run_div(100, -7, 'h3F2, 2, 0, 0, 11, 11, 0, 0);
        run_div(511, -16, 'h3E1, 15, 0, 0, 11, 11, 0, 0);
        run_div(-512, -1, 'h200, 0, 1, 0, 11, 11, 0, 0);
        run_div(37, 0, 'h3FF, 0, 0, 1, 1, 0, 0, 0);
        run_div(100, 7, 14, 2, 0, 0, 14, 14, 1, 1);

        @(negedge clk);
        A = WA'(100); B = WB'(7); start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (5) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        check("mid_rst_quotient", QUOTIENT, 0);
        check("mid_rst_remainder", REMAINDER, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_done", done, 0);
        seen = 1'b0;
        repeat (20) begin
            @(posedge clk);
            #1 if (done) seen = 1'b1;
        end
        check("mid_rst_no_done", seen, 1'b0);
        run_div(-77, 9, 'h3F8, 'h1B, 0, 0, 11, 11, 0, 0);

        repeat (3000) begin
            @(negedge clk);
            rst    = ($urandom_range(0, 199) == 0);
            enable = ($urandom_range(0, 4) != 0);
            start  = ($urandom_range(0, 2) == 0);
            case ($urandom_range(0, 5))
                0: A = {1'b1, {(WA-1){1'b0}}};
                default: A = WA'($urandom);
            endcase
            case ($urandom_range(0, 7))
                0: B = '0;
                1: B = '1;
                2: B = {1'b1, {(WB-1){1'b0}}};
                default: B = WB'($urandom);
            endcase
        end
        @(negedge clk);
        rst = 1'b0; enable = 1'b1; start = 1'b0;
        repeat (30) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
